// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================
// mdio_pkg : shared types and frame constants for the MDIO master
// Revision : 1.0
// ============================================================
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    TA       = 3'd3,
    DATA     = 3'd4,
    DONE     = 3'd5
  } mdio_state_e;

  localparam logic [1:0] ST_CODE   = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] TA_WRITE  = 2'b10;
  localparam int         HDR_BITS  = 14;
  localparam int         DATA_BITS = 16;

  // Post-preamble 32 bits, MSB sent first; read TA/DATA slots are ones since the pin is released.
  function automatic logic [31:0] build_frame(input logic       rdwn,
                                              input logic [4:0] phyad,
                                              input logic [4:0] regad,
                                              input logic [15:0] wdata);
    if (rdwn)
      build_frame = {ST_CODE, OP_READ, phyad, regad, 2'b11, 16'hFFFF};
    else
      build_frame = {ST_CODE, OP_WRITE, phyad, regad, TA_WRITE, wdata};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_mgmt_master_mdc_tick_gen.sv
`default_nettype none
// ============================================================
// mdc_tick_gen : MDC divider with rise/fall tick strobes
// Revision     : 1.0
// ============================================================
module mdc_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_mdc,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int            DW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] TERM = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div;
  logic          r_mdc;
  logic          w_term;

  assign w_term      = i_enable && (r_div == TERM);
  assign o_rise_tick = w_term && !r_mdc;
  assign o_fall_tick = w_term && r_mdc;
  assign o_mdc       = r_mdc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
      r_mdc <= 1'b0;
    end else if (i_clear) begin
      r_div <= '0;
      r_mdc <= 1'b0;
    end else if (i_enable) begin
      if (w_term) begin
        r_div <= '0;
        r_mdc <= ~r_mdc;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdio_mgmt_master.sv
`default_nettype none
// ============================================================
// mdio_mgmt_master : Clause 22 read/write frame master on MDC/MDIO
// Revision         : 1.0
// ============================================================
module mdio_mgmt_master
  import mdio_pkg::*;
#(
  parameter int         CLK_DIV      = 25,
  parameter logic [4:0] PHY_ADDR     = 5'h01,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_phy_request,
  input  logic        i_phy_rdwn,
  input  logic [4:0]  i_phy_addr,
  input  logic [31:0] i_phy_wr_data,
  output logic        o_phy_done,
  output logic [31:0] o_phy_rd_data,
  output logic        o_busy,
  output logic        o_mdc,
  output logic        o_mdio_out,
  output logic        o_mdio_oe,
  input  logic        i_mdio_in
);

  // Period indices (0-based) at which each frame section begins.
  localparam logic [5:0] IDX_HDR  = 6'(PREAMBLE_LEN);
  localparam logic [5:0] IDX_TA   = 6'(PREAMBLE_LEN + HDR_BITS);
  localparam logic [5:0] IDX_DATA = 6'(PREAMBLE_LEN + HDR_BITS + 2);
  localparam logic [5:0] IDX_LAST = 6'(PREAMBLE_LEN + HDR_BITS + 2 + DATA_BITS - 1);

  mdio_state_e r_state, w_next_state;
  logic        r_rdwn, r_busy, r_done, r_mdio_out, r_mdio_oe;
  logic [31:0] r_frame, r_rd_data;
  logic [15:0] r_shift;
  logic [5:0]  r_bit_cnt;
  logic        w_in_frame, w_rise, w_fall, w_frame_bit;
  logic        w_mdio_out, w_mdio_oe, w_done;
  logic [5:0]  w_next_idx;
  logic [4:0]  w_rel;
  logic        w_unused_wr_hi;

  assign w_unused_wr_hi = ^i_phy_wr_data[31:16];
  assign w_in_frame     = r_state inside {PREAMBLE, HEADER, TA, DATA};

  mdc_tick_gen #(.CLK_DIV(CLK_DIV)) u_mdc_tick_gen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_enable    (w_in_frame),
    .i_clear     (!w_in_frame),
    .o_mdc       (o_mdc),
    .o_rise_tick (w_rise),
    .o_fall_tick (w_fall)
  );

  // Bit for the upcoming period; 31-rel is the bitwise inverse of a 5-bit rel.
  assign w_next_idx  = r_bit_cnt + 6'd1;
  assign w_rel       = 5'(w_next_idx - IDX_HDR);
  assign w_frame_bit = (w_next_idx < IDX_HDR) ? 1'b1 : r_frame[~w_rel];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_mdio_out   = r_mdio_out;
    w_mdio_oe    = r_mdio_oe;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        w_mdio_out = 1'b1;
        w_mdio_oe  = 1'b0;
        if (i_phy_request) begin
          w_next_state = PREAMBLE;
          w_mdio_oe    = 1'b1;
        end
      end
      DONE: begin
        w_next_state = IDLE;
        w_mdio_out   = 1'b1;
        w_mdio_oe    = 1'b0;
      end
      default: begin
        if (w_fall) begin
          if (r_bit_cnt == IDX_LAST) begin
            w_next_state = DONE;
            w_mdio_out   = 1'b1;
            w_mdio_oe    = 1'b0;
            w_done       = 1'b1;
          end else begin
            if (w_next_idx == IDX_HDR)       w_next_state = HEADER;
            else if (w_next_idx == IDX_TA)   w_next_state = TA;
            else if (w_next_idx == IDX_DATA) w_next_state = DATA;
            w_mdio_out = w_frame_bit;
            w_mdio_oe  = !r_rdwn || (w_next_idx < IDX_TA);
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mdio_out <= 1'b1;
      r_mdio_oe  <= 1'b0;
      r_rd_data  <= '0;
      r_rdwn     <= 1'b0;
      r_frame    <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_busy     <= (w_next_state != IDLE);
      r_done     <= w_done;
      r_mdio_out <= w_mdio_out;
      r_mdio_oe  <= w_mdio_oe;
      if (r_state == IDLE && i_phy_request) begin
        r_rdwn  <= i_phy_rdwn;
        r_frame <= build_frame(i_phy_rdwn, PHY_ADDR, i_phy_addr, i_phy_wr_data[15:0]);
      end
      if (!w_in_frame)  r_bit_cnt <= '0;
      else if (w_fall)  r_bit_cnt <= w_next_idx;
      if (r_state == DATA && r_rdwn && w_rise)
        r_shift <= {r_shift[14:0], i_mdio_in};
      if (w_done && r_rdwn)
        r_rd_data <= {16'h0, r_shift};
    end
  end

  assign o_busy        = r_busy;
  assign o_phy_done    = r_done;
  assign o_mdio_out    = r_mdio_out;
  assign o_mdio_oe     = r_mdio_oe;
  assign o_phy_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: doc/mdio_mgmt_master.md
Name: mdio_mgmt_master

Overview:
- Serves the PHY management request interface used by the speed poller and other MAC-side clients.
- Accepts one register read or write request at a time and runs an IEEE 802.3 Clause 22 frame on MDC/MDIO.
- Returns a one-cycle done pulse with read data.
- Sits between the speed-control logic and the PHY management pins; tristate buffer lives at top level.

Parameters:
CLK_DIV, 25, i_clk cycles per MDC half-period; legal range >=2 (125 MHz/50 = 2.5 MHz MDC).
PHY_ADDR, 5'h01, PHYAD field sent in every frame.
PREAMBLE_LEN, 32, number of preamble '1' bits; legal range 1..32.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_phy_request  in  1  one-cycle request strobe
i_phy_rdwn  in  1  1=read, 0=write; sampled with request
i_phy_addr  in  5  PHY register address (REGAD); sampled with request
i_phy_wr_data  in  32  write data; bits [15:0] used
o_phy_done  out  1  one-cycle completion pulse
o_phy_rd_data  out  32  {16'h0, read data}; valid in and after done cycle of a read
o_busy  out  1  transaction in progress
o_mdc  out  1  management clock
o_mdio_out  out  1  MDIO output data
o_mdio_oe  out  1  MDIO output enable (1 = drive)
i_mdio_in  in  1  MDIO input from pad

Behaviour:
- Reset: o_phy_done=0, o_phy_rd_data=0, o_busy=0, o_mdc=0, o_mdio_out=1, o_mdio_oe=0; FSM to IDLE; divider and counters cleared. Reset mid-frame aborts immediately. No done is issued. The next request starts a full fresh frame.
- Accept: in IDLE, i_phy_request=1 latches rdwn, addr and wr_data[15:0]. o_busy=1 from the next cycle.
- Requests while o_busy=1 are ignored and not queued. This includes a request in the o_phy_done cycle; busy stays high through done.
- MDC: divider counts 0..CLK_DIV-1 only while busy. At each terminal count o_mdc toggles. o_mdc is low at frame start, so one MDC period is 2*CLK_DIV cycles. o_mdc is held low in IDLE/DONE.
- Frame:
  - Bit sequence: PREAMBLE_LEN ones, then ST=01, OP (read 10 / write 01), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0], MSB first.
  - Bit k is presented on o_mdio_out at the start of MDC period k, i.e. on the cycle o_mdc goes or stays low, and is stable across the rising edge.
  - Total periods = PREAMBLE_LEN+32.
- Write: TA=10. o_mdio_oe=1 for all bits.
- Read:
  - o_mdio_oe=1 through REGAD[0]; 0 from the first TA bit to the end, with o_mdio_out=1.
  - i_mdio_in is sampled on the i_clk cycle at which o_mdc goes 0->1 during each of the 16 DATA periods, shifted in MSB first.
  - The TA bit driven by the PHY is not checked.
- FSM: IDLE -> PREAMBLE -> HEADER (ST, OP, PHYAD, REGAD; 14 bits) -> TA (2 bits) -> DATA (16 bits) -> DONE -> IDLE.
  - A bit counter (6 bits) advances at the end of each MDC period, i.e. the falling toggle.
- DONE (one cycle): o_phy_done=1, o_mdio_oe=0, o_mdc=0.
  - For a read, o_phy_rd_data={16'h0, shift_reg} is updated in the same cycle done is high.
  - For a write, o_phy_rd_data is unchanged.
  - o_busy drops the following cycle.
- Latency: request at cycle T gives o_phy_done at T+1+2*CLK_DIV*(PREAMBLE_LEN+32). CLK_DIV=2, PREAMBLE_LEN=32 gives T+257.
- All outputs are registered.

Decomposition:
- Package mdio_pkg holds:
  - state enum IDLE/PREAMBLE/HEADER/TA/DATA/DONE
  - ST_CODE=2'b01, OP_READ=2'b10, OP_WRITE=2'b01, TA_WRITE=2'b10
  - HDR_BITS=14, DATA_BITS=16
- Sub-module mdc_tick_gen (parameter CLK_DIV): holds the divider and o_mdc. Inputs: enable, clear. Outputs: mdc, rise_tick, fall_tick.

Test Plan:
- Reset release: all outputs at reset values. o_mdc stays 0 for 100 cycles with no request.
- Read, CLK_DIV=2, PHY_ADDR=1, addr=5'h11; PHY model returns 16'h8C00:
  - Captured frame is 32 ones, 0110 00001 10001, then oe=0.
  - o_phy_done at T+257.
  - o_phy_rd_data=32'h0000_8C00.
- Write addr=5'h00, data=32'h0000_1140:
  - Frame is 32 ones, 0101 00001 00000 10 0001000101000000, oe=1 for all 64 bits.
  - Done at T+257; o_phy_rd_data keeps the prior read value.
- Request pulsed at T+50 and in the done cycle: both ignored. Exactly one done; o_busy low one cycle after done.
- Assert i_rst_n=0 during DATA bit 8:
  - Outputs immediately at reset values; no done.
  - A new read then completes normally in 257 cycles.
- Read with i_mdio_in floating high: o_phy_rd_data=32'h0000_FFFF.
- PREAMBLE_LEN=1: frame is 33 periods; done at T+133.
